// File: rtl/div_pkg.sv
// div_pkg: shared types, constants and helpers for the iterative divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam logic [3:0] DIV_CONTROL  = 4'b1010;
    localparam logic [3:0] DIVU_CONTROL = 4'b1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic n, input logic [DIV_WIDTH-1:0] v);
        return n ? -v : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration, shift {rem, quo} left and trial-subtract.
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    assign w_sh   = {i_rem, i_quo[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, i_divisor};
    // rem < divisor holds, so the borrow bit alone tells whether the trial fits
    assign w_ge   = ~w_diff[WIDTH];
    assign o_rem  = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign o_quo  = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle MIPS DIV/DIVU unit; remainder to HI, quotient to LO.
module div_unit import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITERS = DIV_ITERS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(ITERS);

    div_state_t       r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_div, r_hi, r_lo;
    logic             r_neg_q, r_neg_r;
    logic [WIDTH-1:0] w_rem, w_quo;
    logic             w_start, w_dz, w_last;

    assign w_start = start_i & ~annul_i;
    assign w_dz    = divisor_i == '0;
    assign w_last  = r_cnt == CW'(ITERS - 1);
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem    (r_rem),
        .i_quo    (r_quo),
        .i_divisor(r_div),
        .o_rem    (w_rem),
        .o_quo    (w_quo)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        stall_o = 1'b0;
        busy_o  = r_state == BUSY;
        ready_o = (r_state == DONE) & ~annul_i;
        unique case (r_state)
            IDLE: begin
                w_next  = w_start ? (w_dz ? DONE : BUSY) : IDLE;
                stall_o = w_start;
            end
            BUSY: begin
                w_next  = w_last ? DONE : BUSY;
                stall_o = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        if (annul_i) w_next = IDLE;
    end

    // Operands are held as magnitudes; signs are reapplied on the final step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (!annul_i) begin
            if (r_state == IDLE && start_i) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= neg_if(signed_i & dividend_i[WIDTH-1], dividend_i);
                r_div   <= neg_if(signed_i & divisor_i[WIDTH-1], divisor_i);
                r_neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                r_neg_r <= signed_i & dividend_i[WIDTH-1];
                if (w_dz) begin
                    r_hi <= dividend_i;
                    r_lo <= '1;
                end
            end else if (r_state == BUSY) begin
                r_rem <= w_rem;
                r_quo <= w_quo;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_hi <= neg_if(r_neg_r, w_rem);
                    r_lo <= neg_if(r_neg_q, w_quo);
                end
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expected {hi, lo} queued at issue, popped on ready.
module tb_div_unit;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sgn = 1'b0, annul = 1'b0;
    logic [31:0] dvd = '0, dvs = '0;
    logic        stall, busy, ready;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;
    int          lat, stalls, start_stall;
    logic [63:0] sb[$];
    logic [63:0] exp_r;
    logic [31:0] prev_hi, prev_lo;

    always #5 clk = ~clk;

    div_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn), .annul_i(annul),
        .dividend_i(dvd), .divisor_i(dvs),
        .stall_o(stall), .busy_o(busy), .ready_o(ready), .hi_o(hi), .lo_o(lo)
    );

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input bit hold);
        @(negedge clk);
        sgn = s; dvd = a; dvs = b; start = 1'b1;
        sb.push_back(model(s, a, b));
        #1 start_stall = int'(stall);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_ready();
        lat = 0;
        stalls = start_stall;
        for (int i = 1; i <= 40; i++) begin
            #1 stalls += int'(stall);
            if (ready) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1 checks++;
        if ({stall, busy, ready, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b busy=%b ready=%b hi=%h lo=%h, expected all zero", stall, busy, ready, hi, lo);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_divu();
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d cycles, expected 33", lat); end
        checks++; if (stalls !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d, expected 33", stalls); end
        checks++; if (lo !== exp_r[31:0]) begin errors++; $display("FAIL divu_lo: got %h, expected %h", lo, exp_r[31:0]); end
        checks++; if (hi !== exp_r[63:32]) begin errors++; $display("FAIL divu_hi: got %h, expected %h", hi, exp_r[63:32]); end
        @(negedge clk) #1 checks++;
        if (ready !== 1'b0 || lo !== exp_r[31:0]) begin
            errors++;
            $display("FAIL ready_pulse_hold: got ready=%b lo=%h, expected ready=0 lo=%h", ready, lo, exp_r[31:0]);
        end
    endtask

    task automatic test_signed();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if (lo !== exp_r[31:0]) begin errors++; $display("FAIL div_neg_lo: got %h, expected %h", lo, exp_r[31:0]); end
        checks++; if (hi !== exp_r[63:32]) begin errors++; $display("FAIL div_neg_hi: got %h, expected %h", hi, exp_r[63:32]); end
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if (lo !== exp_r[31:0]) begin errors++; $display("FAIL divu_big_lo: got %h, expected %h", lo, exp_r[31:0]); end
        checks++; if (hi !== exp_r[63:32]) begin errors++; $display("FAIL divu_big_hi: got %h, expected %h", hi, exp_r[63:32]); end
    endtask

    task automatic test_overflow();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_latency: got %0d cycles, expected 33", lat); end
        checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL ovf_result: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, exp_r[63:32], exp_r[31:0]); end
    endtask

    task automatic test_div_zero();
        issue(1'b0, 32'h1234, 32'd0, 1'b0);
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d cycles, expected 1", lat); end
        checks++; if (stalls !== 1) begin errors++; $display("FAIL dz_stall_cycles: got %0d, expected 1", stalls); end
        checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL dz_result: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, exp_r[63:32], exp_r[31:0]); end
    endtask

    task automatic test_annul();
        int seen;
        prev_hi = hi;
        prev_lo = lo;
        issue(1'b0, 32'd1000, 32'd7, 1'b0);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk) annul = 1'b0;
        #1 checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle: got busy=%b stall=%b, expected 0 0", busy, stall);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk) #1 seen += int'(ready);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d pulses, expected 0", seen); end
        checks++; if ({hi, lo} !== {prev_hi, prev_lo}) begin errors++; $display("FAIL annul_hold: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, prev_hi, prev_lo); end
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dvd = 32'd50; dvs = 32'd5;
        #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL annul_start_stall: got %b, expected 0", stall); end
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1 checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_start_busy: got %b, expected 0", busy); end
        issue(1'b0, 32'd9, 32'd3, 1'b0);
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL after_annul_latency: got %0d cycles, expected 33", lat); end
        checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL after_annul_result: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, exp_r[63:32], exp_r[31:0]); end
    endtask

    task automatic test_async_reset();
        issue(1'b1, 32'h1234_5678, 32'h321, 1'b0);
        void'(sb.pop_back());
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checks++;
        if ({stall, busy, ready, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b busy=%b ready=%b hi=%h lo=%h, expected all zero", stall, busy, ready, hi, lo);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'd500, 32'd9, 1'b1);
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL b2b_first: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, exp_r[63:32], exp_r[31:0]); end
        sgn = 1'b1; dvd = 32'hFFFF_FF9C; dvs = 32'd7;
        sb.push_back(model(1'b1, 32'hFFFF_FF9C, 32'd7));
        @(negedge clk) #1 checks++;
        if (busy !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_restart: got busy=%b stall=%b, expected busy=0 stall=1", busy, stall);
        end
        start_stall = int'(stall);
        @(negedge clk) start = 1'b0;
        wait_ready();
        exp_r = sb.pop_front();
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d cycles, expected 33", lat); end
        checks++; if ({hi, lo} !== exp_r) begin errors++; $display("FAIL b2b_second: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, exp_r[63:32], exp_r[31:0]); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a, b;
            bit s;
            s = bit'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 0) b = 32'd1;
            issue(s, a, b, 1'b0);
            wait_ready();
            exp_r = sb.pop_front();
            checks++;
            if ({hi, lo} !== exp_r) begin
                errors++;
                $display("FAIL random_%0d s=%0d a=%h b=%h: got hi=%h lo=%h, expected hi=%h lo=%h", k, s, a, b, hi, lo, exp_r[63:32], exp_r[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
